// File: rtl/arm_id_ex_operand.sv
// ID/EX operand stage: forwarding mux, load-use bubble FSM, EX pipeline register.
// Define ARM_WB_FWD_EN to let the WB stage forward; otherwise rely on RF write-through.
module arm_id_ex_operand #(
    parameter int REG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              id_valid,
    input  logic [31:0]       id_inst,
    input  logic [REG_W-1:0]  id_rn_num,
    input  logic [REG_W-1:0]  id_rm_num,
    input  logic [REG_W-1:0]  id_rs_num,
    input  logic [2:0]        id_uses,
    input  logic [DATA_W-1:0] id_rn_data,
    input  logic [DATA_W-1:0] id_rm_data,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic              ex_wr_en,
    input  logic [REG_W-1:0]  ex_wr_num,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_is_load,
    input  logic              mem_wr_en,
    input  logic [REG_W-1:0]  mem_wr_num,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_wr_en,
    input  logic [REG_W-1:0]  wb_wr_num,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_inst,
    output logic [11:0]       ex_inst_11_0,
    output logic              ex_is_imm,
    output logic [DATA_W-1:0] ex_rn_data,
    output logic [DATA_W-1:0] ex_rm_data,
    output logic [DATA_W-1:0] ex_rs_data
);

    typedef enum logic {RUN, BUBBLE} state_t;

    localparam logic [REG_W-1:0] PC_NUM = REG_W'(15);

    state_t            r_state;
    logic [REG_W-1:0]  w_num [3];
    logic [DATA_W-1:0] w_rf  [3];
    logic [DATA_W-1:0] w_op  [3];
    logic [2:0]        w_ex_hit;
    logic [2:0]        w_mem_hit;
    logic              w_load_use;

    assign w_num[0] = id_rn_num;
    assign w_num[1] = id_rm_num;
    assign w_num[2] = id_rs_num;
    assign w_rf[0]  = id_rn_data;
    assign w_rf[1]  = id_rm_data;
    assign w_rf[2]  = id_rs_data;

`ifndef ARM_WB_FWD_EN
    logic w_wb_unused;
    assign w_wb_unused = ^{wb_wr_en, wb_wr_num, wb_result};
`endif

    // Later assignments win, so the youngest producer takes priority.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_ex_hit[i]  = ex_wr_en && (ex_wr_num == w_num[i])
                           && (w_num[i] != PC_NUM);
            w_mem_hit[i] = mem_wr_en && (mem_wr_num == w_num[i])
                           && (w_num[i] != PC_NUM);
            w_op[i] = w_rf[i];
`ifdef ARM_WB_FWD_EN
            if (wb_wr_en && (wb_wr_num == w_num[i])
                && (w_num[i] != PC_NUM))
                w_op[i] = wb_result;
`endif
            if (w_mem_hit[i])
                w_op[i] = mem_result;
            if (w_ex_hit[i])
                w_op[i] = ex_result;
        end
    end

    assign w_load_use = id_valid && ex_is_load && |(id_uses & w_ex_hit);

    assign stall = rst_b && (r_state == RUN) && w_load_use && !flush;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= RUN;
            ex_valid     <= 1'b0;
            ex_inst      <= '0;
            ex_inst_11_0 <= '0;
            ex_is_imm    <= 1'b0;
            ex_rn_data   <= '0;
            ex_rm_data   <= '0;
            ex_rs_data   <= '0;
        end else if (stall) begin
            r_state  <= BUBBLE;
            ex_valid <= 1'b0;
        end else begin
            r_state      <= RUN;
            ex_valid     <= id_valid && !flush;
            ex_inst      <= id_inst;
            ex_inst_11_0 <= id_inst[11:0];
            ex_is_imm    <= id_inst[25];
            ex_rn_data   <= w_op[0];
            ex_rm_data   <= w_op[1];
            ex_rs_data   <= w_op[2];
        end
    end

endmodule

// File: tb/tb_arm_id_ex_operand.sv
// Bench for arm_id_ex_operand: directed scenarios plus randomized run
// against a behavioural model of forwarding priority and load-use bubbles.
module tb_arm_id_ex_operand;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [3:0]  id_rn_num, id_rm_num, id_rs_num;
    logic [2:0]  id_uses;
    logic [31:0] id_rn_data, id_rm_data, id_rs_data;
    logic        ex_wr_en, mem_wr_en, wb_wr_en;
    logic [3:0]  ex_wr_num, mem_wr_num, wb_wr_num;
    logic [31:0] ex_result, mem_result, wb_result;
    logic        ex_is_load;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic [11:0] ex_inst_11_0;
    logic        ex_is_imm;
    logic [31:0] ex_rn_data, ex_rm_data, ex_rs_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arm_id_ex_operand #(.REG_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst_b(rst_b),
        .id_valid(id_valid), .id_inst(id_inst),
        .id_rn_num(id_rn_num), .id_rm_num(id_rm_num), .id_rs_num(id_rs_num),
        .id_uses(id_uses),
        .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_rs_data(id_rs_data),
        .ex_wr_en(ex_wr_en), .ex_wr_num(ex_wr_num), .ex_result(ex_result),
        .ex_is_load(ex_is_load),
        .mem_wr_en(mem_wr_en), .mem_wr_num(mem_wr_num), .mem_result(mem_result),
        .wb_wr_en(wb_wr_en), .wb_wr_num(wb_wr_num), .wb_result(wb_result),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_inst_11_0(ex_inst_11_0),
        .ex_is_imm(ex_is_imm),
        .ex_rn_data(ex_rn_data), .ex_rm_data(ex_rm_data), .ex_rs_data(ex_rs_data)
    );

    // Expected operand: youngest matching writer, never r15.
    function automatic logic [31:0] ref_op(input logic [3:0] n, input logic [31:0] rf);
        if (n == 4'd15) return rf;
        if (ex_wr_en && ex_wr_num == n) return ex_result;
        if (mem_wr_en && mem_wr_num == n) return mem_result;
`ifdef ARM_WB_FWD_EN
        if (wb_wr_en && wb_wr_num == n) return wb_result;
`endif
        return rf;
    endfunction

    function automatic bit ref_lu();
        bit h = 0;
        if (id_uses[0] && id_rn_num == ex_wr_num && id_rn_num != 15) h = 1;
        if (id_uses[1] && id_rm_num == ex_wr_num && id_rm_num != 15) h = 1;
        if (id_uses[2] && id_rs_num == ex_wr_num && id_rs_num != 15) h = 1;
        return id_valid && ex_wr_en && ex_is_load && h;
    endfunction

    task automatic clr();
        id_valid = 0; id_inst = 0; id_uses = 0;
        id_rn_num = 0; id_rm_num = 0; id_rs_num = 0;
        id_rn_data = 0; id_rm_data = 0; id_rs_data = 0;
        ex_wr_en = 0; ex_wr_num = 0; ex_result = 0; ex_is_load = 0;
        mem_wr_en = 0; mem_wr_num = 0; mem_result = 0;
        wb_wr_en = 0; wb_wr_num = 0; wb_result = 0;
        flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        id_valid = 1; id_inst = 32'hE1A0_0212;
        id_rs_num = 4'd2; id_uses = 3'b100; id_rs_data = 32'h22;
        ex_wr_en = 1; ex_wr_num = 4'd2; ex_is_load = 1; ex_result = 32'hDEAD;
    endtask

    task automatic test_reset();
        clr();
        set_lu();
        rst_b = 1;
        #2 rst_b = 0;
        #1;
        total++;
        if ({ex_valid, ex_inst, ex_inst_11_0, ex_is_imm, ex_rn_data, ex_rm_data, ex_rs_data} !== '0) begin
            bad++;
            $display("FAIL reset_outs got=%h exp=0", {ex_valid, ex_inst, ex_rn_data, ex_rm_data, ex_rs_data});
        end
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
        tick();
        total++;
        if (ex_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hold_valid got=%b exp=0", ex_valid);
        end
        rst_b = 1;
        clr();
        tick();
    endtask

    task automatic test_ex_fwd();
        clr();
        id_valid = 1; id_inst = 32'h0200_0ABC;
        ex_wr_en = 1; ex_wr_num = 4'd3; ex_result = 32'h11;
        id_rm_num = 4'd3; id_rm_data = 32'h99;
        tick();
        total++;
        if (ex_rm_data !== 32'h11) begin
            bad++; $display("FAIL ex_fwd got=%h exp=11", ex_rm_data);
        end
        total++;
        if ({ex_valid, ex_inst, ex_inst_11_0, ex_is_imm} !== {1'b1, 32'h0200_0ABC, 12'hABC, 1'b1}) begin
            bad++;
            $display("FAIL ex_fields got=%b %h %h %b exp=1 02000abc abc 1", ex_valid, ex_inst, ex_inst_11_0, ex_is_imm);
        end
    endtask

    task automatic test_priority();
        clr();
        id_valid = 1; id_inst = 32'hE080_0001;
        ex_wr_en = 1; ex_wr_num = 4'd5; ex_result = 32'hA;
        mem_wr_en = 1; mem_wr_num = 4'd5; mem_result = 32'hB;
        id_rn_num = 4'd5; id_rn_data = 32'h55;
        tick();
        total++;
        if (ex_rn_data !== 32'hA) begin
            bad++; $display("FAIL prio_ex_mem got=%h exp=a", ex_rn_data);
        end
        ex_wr_num = 4'd6;
        tick();
        total++;
        if (ex_rn_data !== 32'hB) begin
            bad++; $display("FAIL prio_mem_only got=%h exp=b", ex_rn_data);
        end
        mem_wr_en = 0;
        tick();
        total++;
        if (ex_rn_data !== 32'h55) begin
            bad++; $display("FAIL prio_rf got=%h exp=55", ex_rn_data);
        end
    endtask

    task automatic test_r15();
        clr();
        id_valid = 1;
        ex_wr_en = 1; ex_wr_num = 4'd15; ex_result = 32'h5;
        mem_wr_en = 1; mem_wr_num = 4'd15; mem_result = 32'h6;
        id_rn_num = 4'd15; id_rn_data = 32'h108;
        tick();
        total++;
        if (ex_rn_data !== 32'h108) begin
            bad++; $display("FAIL r15 got=%h exp=108", ex_rn_data);
        end
    endtask

    task automatic test_wb();
        logic [31:0] exp;
        clr();
        id_valid = 1;
        wb_wr_en = 1; wb_wr_num = 4'd7; wb_result = 32'h77;
        id_rm_num = 4'd7; id_rm_data = 32'h70;
`ifdef ARM_WB_FWD_EN
        exp = 32'h77;
`else
        exp = 32'h70;
`endif
        tick();
        total++;
        if (ex_rm_data !== exp) begin
            bad++; $display("FAIL wb_only got=%h exp=%h", ex_rm_data, exp);
        end
    endtask

    task automatic test_load_use();
        clr();
        id_valid = 1; id_inst = 32'hE000_0111;
        tick();
        set_lu();
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL lu_stall got=%b exp=1", stall);
        end
        tick();
        total++;
        if (ex_valid !== 1'b0 || ex_inst !== 32'hE000_0111) begin
            bad++; $display("FAIL lu_bubble got=%b %h exp=0 e0000111", ex_valid, ex_inst);
        end
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL lu_bubble_stall got=%b exp=0", stall);
        end
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_wr_num = 4'd2; mem_result = 32'h1234;
        tick();
        total++;
        if ({ex_valid, ex_rs_data, ex_inst} !== {1'b1, 32'h1234, 32'hE1A0_0212}) begin
            bad++; $display("FAIL lu_resume got=%b %h %h exp=1 1234 e1a00212", ex_valid, ex_rs_data, ex_inst);
        end
        clr();
        tick();
    endtask

    task automatic test_unused_and_invalid();
        clr();
        id_valid = 1;
        ex_wr_en = 1; ex_wr_num = 4'd4; ex_is_load = 1; ex_result = 32'h44;
        id_rm_num = 4'd4; id_rm_data = 32'h40; id_uses = 3'b101;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL unused_no_lu got=%b exp=0", stall);
        end
        tick();
        total++;
        if (ex_rm_data !== 32'h44 || ex_valid !== 1'b1) begin
            bad++; $display("FAIL unused_fwd got=%h %b exp=44 1", ex_rm_data, ex_valid);
        end
        set_lu();
        id_valid = 0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL invalid_no_stall got=%b exp=0", stall);
        end
        tick();
        total++;
        if (ex_valid !== 1'b0) begin
            bad++; $display("FAIL invalid_valid got=%b exp=0", ex_valid);
        end
    endtask

    task automatic test_flush();
        clr();
        set_lu();
        flush = 1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL flush_stall got=%b exp=0", stall);
        end
        tick();
        total++;
        if (ex_valid !== 1'b0) begin
            bad++; $display("FAIL flush_valid got=%b exp=0", ex_valid);
        end
        flush = 0;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL flush_run got=%b exp=1", stall);
        end
        tick();
        flush = 1;
        tick();
        total++;
        if (ex_valid !== 1'b0) begin
            bad++; $display("FAIL flush_bubble_valid got=%b exp=0", ex_valid);
        end
        clr();
        tick();
    endtask

    task automatic test_reset_bubble();
        clr();
        set_lu();
        tick();
        #1 rst_b = 0;
        #1;
        total++;
        if (ex_valid !== 1'b0 || ex_rs_data !== 32'h0 || stall !== 1'b0) begin
            bad++; $display("FAIL rst_mid got=%b %h %b exp=0 0 0", ex_valid, ex_rs_data, stall);
        end
        rst_b = 1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL rst_abandon got=%b exp=1", stall);
        end
        clr();
        tick();
    endtask

    task automatic test_random();
        bit          bub;
        bit          exp_st;
        logic        e_v;
        logic [31:0] e_inst, e_rn, e_rm, e_rs;
        logic [3:0]  n [7];
        clr();
        rst_b = 0;
        #2 rst_b = 1;
        bub = 0; e_v = 0; e_inst = 0; e_rn = 0; e_rm = 0; e_rs = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 7; k++)
                n[k] = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            id_valid = 1'($urandom_range(0, 7) != 0);
            id_inst = $urandom;
            id_rn_num = n[0]; id_rm_num = n[1]; id_rs_num = n[2];
            id_uses = 3'($urandom);
            id_rn_data = $urandom; id_rm_data = $urandom; id_rs_data = $urandom;
            ex_wr_en = 1'($urandom); ex_wr_num = n[3]; ex_result = $urandom;
            ex_is_load = 1'($urandom);
            mem_wr_en = 1'($urandom); mem_wr_num = n[4]; mem_result = $urandom;
            wb_wr_en = 1'($urandom); wb_wr_num = n[5]; wb_result = $urandom;
            flush = 1'($urandom_range(0, 9) == 0);
            #1;
            exp_st = !bub && ref_lu() && !flush;
            total++;
            if (stall !== exp_st) begin
                bad++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, exp_st);
            end
            if (exp_st) begin
                e_v = 0; bub = 1;
            end else begin
                bub = 0;
                e_v = id_valid && !flush;
                e_inst = id_inst;
                e_rn = ref_op(id_rn_num, id_rn_data);
                e_rm = ref_op(id_rm_num, id_rm_data);
                e_rs = ref_op(id_rs_num, id_rs_data);
            end
            tick();
            total++;
            if ({ex_valid, ex_inst, ex_inst_11_0, ex_is_imm, ex_rn_data, ex_rm_data, ex_rs_data}
                !== {e_v, e_inst, e_inst[11:0], e_inst[25], e_rn, e_rm, e_rs}) begin
                bad++;
                $display("FAIL rnd_out c=%0d got=%b %h %h %h %h exp=%b %h %h %h %h", c,
                         ex_valid, ex_inst, ex_rn_data, ex_rm_data, ex_rs_data,
                         e_v, e_inst, e_rn, e_rm, e_rs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_priority();
        test_r15();
        test_wb();
        test_load_use();
        test_unused_and_invalid();
        test_flush();
        test_reset_bubble();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_id_ex_operand.md
ARM_ID_EX_OPERAND -- requirements
Module: arm_id_ex_operand

Interface
Parameters:
REQ-001 SHALL have parameter REG_W, default 4, meaning register-number width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning datapath width.
Ports (name, direction, width, meaning):
REQ-003 SHALL have port clk, in, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b, in, 1, reset, asynchronous and active-low.
REQ-005 SHALL have decode-side ports:
- id_valid, in, 1
- id_inst, in, 32
- id_rn_num, id_rm_num, id_rs_num, in, REG_W each
- id_uses, in, 3, {rs,rm,rn} read enables
- id_rn_data, id_rm_data, id_rs_data, in, DATA_W each, register-file read data
REQ-006 SHALL have result-source ports per stage X in {ex, mem, wb}: X_wr_en in 1; X_wr_num in REG_W; X_result in DATA_W. SHALL also have ex_is_load, in, 1, meaning the EX instruction is a load whose data is not yet available.
REQ-007 SHALL have flush, in, 1, meaning kill the instruction entering EX.
REQ-008 SHALL have stall, out, 1, meaning hold IF/ID and keep id_* stable.
REQ-009 SHALL have execute-side outputs, all registered:
- ex_valid, 1
- ex_inst, 32
- ex_inst_11_0, 12
- ex_is_imm, 1
- ex_rn_data, ex_rm_data, ex_rs_data, DATA_W each; these feed the barrel shifter and ALU.

Function
REQ-010 SHALL resolve each operand combinationally, priority EX > MEM > WB > register file. A source matches when X_wr_en=1, X_wr_num equals the operand number, and the operand number is not 15.
REQ-011 SHALL never forward to register 15; id_*_data SHALL pass through unchanged, since the register file supplies PC+8.
REQ-012 SHALL detect load-use: id_valid & ex_wr_en & ex_is_load & any enabled operand matching ex_wr_num (not 15).
REQ-013 SHALL use FSM states RUN and BUBBLE:
- RUN -> BUBBLE on load-use with flush=0.
- BUBBLE -> RUN unconditionally after one cycle.
REQ-014 SHALL assert stall combinationally in RUN when load-use is detected and flush=0; SHALL deassert stall in BUBBLE.
REQ-015 In RUN without stall, each clock edge SHALL register:
- ex_valid <= id_valid & ~flush
- ex_inst <= id_inst
- ex_inst_11_0 <= id_inst[11:0]
- ex_is_imm <= id_inst[25]
- the resolved operands
Latency is 1 cycle.
REQ-016 On a stall cycle, the next edge SHALL set ex_valid=0 and leave the other ex_* outputs unchanged.
REQ-017 In BUBBLE, operands SHALL re-resolve; the loaded value now arrives via mem_*. The instruction SHALL be captured at the next edge.
REQ-018 flush SHALL dominate stall and BUBBLE: next ex_valid=0, next state RUN, and stall=0 in the flush cycle.
REQ-019 Operands whose id_uses bit is 0 SHALL still be registered (resolved value) but SHALL NOT cause load-use.
REQ-020 With simultaneous matches in EX and MEM, the EX value SHALL win. With id_valid=0, stall SHALL be 0.

Reset
REQ-021 While rst_b=0, asynchronously: ex_valid=0, ex_inst=0, ex_inst_11_0=0, ex_is_imm=0, all ex_*_data=0, state=RUN, stall=0.
REQ-022 Reset asserted mid-BUBBLE SHALL abandon the bubble. The first edge after deassertion SHALL behave as RUN.

Configuration
REQ-023 Macro ARM_WB_FWD_EN:
- When defined, the WB source participates in forwarding per REQ-010.
- When undefined, wb_* ports remain present but are ignored, and the register file SHALL be relied on for write-through. Priority then becomes EX > MEM > register file.

Verification
REQ-024 Bench SHALL cover EX forward: ex_wr_en=1, ex_wr_num=3, ex_result=0x11; id_rm_num=3, id_rm_data=0x99 -> ex_rm_data=0x11 next cycle.
REQ-025 Bench SHALL cover priority: EX and MEM both write r5 (0xA, 0xB) -> ex_rn_data=0xA.
REQ-026 Bench SHALL cover load-use: ex_is_load=1 to r2, id uses rs=r2 -> stall=1 for exactly 1 cycle, one ex_valid=0 bubble, then ex_rs_data=mem_result (0x1234).
REQ-027 Bench SHALL cover r15: EX writes r15=0x5; id_rn_num=15, id_rn_data=0x108 -> ex_rn_data=0x108.
REQ-028 Bench SHALL cover flush during load-use: stall=0, ex_valid=0 next cycle, FSM in RUN.
REQ-029 Bench SHALL cover WB-only match r7=0x77: with ARM_WB_FWD_EN -> 0x77; without -> id_rm_data.
